// File: rtl/vram_pkg.sv
// Shared types and constants for the ULA screen-bank shadow RAM.
package vram_pkg;

  localparam int unsigned VRAM_AW = 13;
  localparam int unsigned DATA_W  = 8;

  localparam logic [2:0] PAGE_SCR0 = 3'd5;
  localparam logic [2:0] PAGE_SCR1 = 3'd7;

  typedef struct packed {
    logic                 bank;
    logic [VRAM_AW-1:0]   addr;
    logic [DATA_W-1:0]    data;
  } vram_wr_t;

  typedef enum logic {
    SLOT_RD = 1'b0,
    SLOT_WR = 1'b1
  } slot_t;

  // Returns {hit, bank_bit} for a CPU address given the current paging state.
  function automatic logic [1:0] bank_decode(input logic [15:0] a,
                                             input logic        m128,
                                             input logic [2:0]  page);
    logic hit;
    logic bank;
    hit  = 1'b0;
    bank = 1'b0;
    if (!a[13]) begin
      if (a[15:14] == 2'b01) begin
        hit = 1'b1;
      end else if (m128 && (a[15:14] == 2'b11)) begin
        if (page == PAGE_SCR0) begin
          hit = 1'b1;
        end else if (page == PAGE_SCR1) begin
          hit  = 1'b1;
          bank = 1'b1;
        end
      end
    end
    return {hit, bank};
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO holding snooped screen writes until a write slot.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  vram_wr_t      i_data,
  input  logic          i_pop,
  output vram_wr_t      o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  vram_wr_t        r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_pop;
  logic            w_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vram_shadow_ram.sv
// Dual-bank screen RAM: video reads on even slots, queued CPU snoop writes on odd slots.
module vram_shadow_ram
  import vram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = 13
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic [AW-1:0] vram_address,
  input  logic          vram_shadow,
  output logic [7:0]    vram_data,
  input  logic [15:0]   A,
  input  logic [7:0]    D,
  input  logic          nMREQ,
  input  logic          nWR,
  input  logic          nRFSH,
  input  logic          m128,
  input  logic [2:0]    page_ram_sel,
  output logic          wr_pending,
  output logic          overflow
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned MEM_N = 2 ** (AW + 1);

  logic [7:0]    r_mem [MEM_N];
  logic [15:0]   r_a;
  logic [7:0]    r_d;
  logic          r_nmreq;
  logic          r_nwr;
  logic          r_nrfsh;
  logic          r_m128;
  logic [2:0]    r_page;
  logic          r_arm;
  slot_t         r_slot;
  logic [7:0]    r_vram_data;
  logic          r_overflow;

  logic [1:0]    w_dec;
  logic          w_capture;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  vram_wr_t      w_entry;
  vram_wr_t      w_head;

  assign w_dec     = bank_decode(r_a, r_m128, r_page);
  assign w_capture = ~r_nmreq & ~r_nwr & r_nrfsh & r_arm;
  assign w_push    = w_capture & w_dec[1];
  assign w_pop     = (r_slot == SLOT_WR) & ~w_empty;
  assign w_entry   = '{bank: w_dec[0], addr: r_a[12:0], data: r_d};

  assign vram_data  = r_vram_data;
  assign wr_pending = (w_count != '0);
  assign overflow   = r_overflow;

  vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (nRESET),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Single-port array: written only in write slots, read only in read slots.
  always_ff @(posedge CLK) begin
    if (w_pop) begin
      r_mem[{w_head.bank, w_head.addr[AW-1:0]}] <= w_head.data;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_a         <= '0;
      r_d         <= '0;
      r_nmreq     <= 1'b1;
      r_nwr       <= 1'b1;
      r_nrfsh     <= 1'b1;
      r_m128      <= 1'b0;
      r_page      <= '0;
      r_arm       <= 1'b1;
      r_slot      <= SLOT_RD;
      r_vram_data <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_a     <= A;
      r_d     <= D;
      r_nmreq <= nMREQ;
      r_nwr   <= nWR;
      r_nrfsh <= nRFSH;
      r_m128  <= m128;
      r_page  <= page_ram_sel;
      r_slot  <= (r_slot == SLOT_RD) ? SLOT_WR : SLOT_RD;
      // One capture per write cycle, however long nWR is held low.
      if (w_capture) begin
        r_arm <= 1'b0;
      end else if (r_nwr) begin
        r_arm <= 1'b1;
      end
      if (r_slot == SLOT_RD) begin
        r_vram_data <= r_mem[{vram_shadow, vram_address}];
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vram_shadow_ram.sv
// Scoreboard bench for vram_shadow_ram: snooped writes, bank decode, overflow, slot timing, reset.
module tb_vram_shadow_ram;
  import vram_pkg::*;

  logic        CLK;
  logic        nRESET;
  logic [12:0] vram_address;
  logic        vram_shadow;
  logic [7:0]  vram_data;
  logic [15:0] A;
  logic [7:0]  D;
  logic        nMREQ;
  logic        nWR;
  logic        nRFSH;
  logic        m128;
  logic [2:0]  page_ram_sel;
  logic        wr_pending;
  logic        overflow;

  vram_shadow_ram #(.FIFO_DEPTH(4), .AW(13)) dut (
    .CLK          (CLK),
    .nRESET       (nRESET),
    .vram_address (vram_address),
    .vram_shadow  (vram_shadow),
    .vram_data    (vram_data),
    .A            (A),
    .D            (D),
    .nMREQ        (nMREQ),
    .nWR          (nWR),
    .nRFSH        (nRFSH),
    .m128         (m128),
    .page_ram_sel (page_ram_sel),
    .wr_pending   (wr_pending),
    .overflow     (overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model [16384];
  logic [7:0] exp_q [$];

  bit mon_en = 1'b0;
  int pend_seen = 0;
  int peak_cnt = 0;
  int rises = 0;
  logic prev_pend = 1'b0;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (wr_pending) pend_seen++;
      if (int'(dut.w_count) > peak_cnt) peak_cnt = int'(dut.w_count);
      if (wr_pending && !prev_pend) rises++;
    end
    prev_pend = wr_pending;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
    A = addr;
    D = data;
    nMREQ = 1'b0;
    nWR = 1'b0;
    tick(hold);
    nWR = 1'b1;
    nMREQ = 1'b1;
    tick(2);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && wr_pending; i++) tick(1);
    check_eq(tag, 32'(wr_pending), 32'd0);
  endtask

  task automatic read_check(input string tag, input logic sh, input logic [12:0] addr);
    vram_shadow = sh;
    vram_address = addr;
    exp_q.push_back(model[{sh, addr}]);
    tick(3);
    check_eq(tag, 32'(vram_data), 32'(exp_q.pop_front()));
  endtask

  initial begin
    logic [7:0] ref_v;
    int changes;
    nRESET = 1'b0; A = '0; D = '0; nMREQ = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
    m128 = 1'b0; page_ram_sel = 3'd0; vram_shadow = 1'b0; vram_address = '0;
    tick(3);
    check_eq("rst_data", 32'(vram_data), 32'h00);
    check_eq("rst_pend", 32'(wr_pending), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    nRESET = 1'b1;
    tick(2);

    // Basic 4000h snoop into bank 5
    cpu_write(16'h4000, 8'hA5, 2);
    model[14'h0000] = 8'hA5;
    wait_idle("t1_idle");
    read_check("t1_rd", 1'b0, 13'h0000);

    // 128K paging: page 7 at C000h is the shadow bank, page 5 at C000h is bank 5
    m128 = 1'b1;
    cpu_write(16'h4123, 8'h11, 2);
    page_ram_sel = 3'd7;
    cpu_write(16'hC123, 8'h3C, 2);
    page_ram_sel = 3'd5;
    cpu_write(16'hC456, 8'h77, 2);
    model[14'h0123] = 8'h11;
    model[14'h2123] = 8'h3C;
    model[14'h0456] = 8'h77;
    wait_idle("t2_idle");
    read_check("t2_shadow", 1'b1, 13'h0123);
    read_check("t2_normal", 1'b0, 13'h0123);
    read_check("t2_page5", 1'b0, 13'h0456);

    // Non-decoding writes must never reach the FIFO
    pend_seen = 0;
    mon_en = 1'b1;
    page_ram_sel = 3'd5;
    cpu_write(16'hE000, 8'h5A, 2);
    page_ram_sel = 3'd2;
    cpu_write(16'hC000, 8'h5A, 2);
    cpu_write(16'h8000, 8'h5A, 2);
    m128 = 1'b0;
    page_ram_sel = 3'd5;
    cpu_write(16'hC000, 8'h5A, 2);
    tick(4);
    mon_en = 1'b0;
    check_eq("t3_nopush", 32'(pend_seen), 32'd0);
    read_check("t3_unchanged", 1'b0, 13'h0000);
    cpu_write(16'h4001, 8'h66, 2);
    model[14'h0001] = 8'h66;
    wait_idle("t3_idle");
    read_check("t3_48k", 1'b0, 13'h0001);

    // Stretched write: nWR low for 20 CLK yields one entry
    peak_cnt = 0;
    rises = 0;
    mon_en = 1'b1;
    cpu_write(16'h4002, 8'h99, 20);
    wait_idle("t4_idle");
    mon_en = 1'b0;
    model[14'h0002] = 8'h99;
    check_eq("t4_peak", 32'(peak_cnt), 32'd1);
    check_eq("t4_rises", 32'(rises), 32'd1);
    check_eq("t4_ovf", 32'(overflow), 32'd0);
    read_check("t4_rd", 1'b0, 13'h0002);

    // Drain blocked: fill the FIFO, then one more write overflows
    force dut.r_slot = SLOT_RD;
    for (int i = 0; i < 4; i++) begin
      cpu_write(16'h4010 + 16'(i), 8'h10 + 8'(i), 2);
      model[14'h0010 + 14'(i)] = 8'h10 + 8'(i);
    end
    check_eq("t5_full_noovf", 32'(overflow), 32'd0);
    check_eq("t5_count4", 32'(dut.w_count), 32'd4);
    check_eq("t5_pend", 32'(wr_pending), 32'd1);
    cpu_write(16'h4000, 8'hFF, 2);
    check_eq("t5_ovf", 32'(overflow), 32'd1);
    check_eq("t5_count_hold", 32'(dut.w_count), 32'd4);
    release dut.r_slot;
    wait_idle("t5_idle");
    read_check("t5_first", 1'b0, 13'h0010);
    read_check("t5_last", 1'b0, 13'h0013);
    read_check("t5_dropped", 1'b0, 13'h0000);
    check_eq("t5_sticky", 32'(overflow), 32'd1);

    // Address toggling every CLK: only read-slot edges sample it
    cpu_write(16'h5800, 8'hC3, 2);
    model[14'h1800] = 8'hC3;
    wait_idle("t6_idle");
    vram_shadow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vram_address = (i % 2 == 0) ? 13'h1800 : 13'h0000;
      tick(1);
    end
    ref_v = vram_data;
    changes = 0;
    for (int i = 0; i < 12; i++) begin
      vram_address = (i % 2 == 0) ? 13'h1800 : 13'h0000;
      tick(1);
      if (vram_data !== ref_v) changes++;
    end
    check_eq("t6_stable", 32'(changes), 32'd0);
    check_eq("t6_value", 32'((ref_v == 8'hA5) || (ref_v == 8'hC3)), 32'd1);
    check_eq("t6_sticky", 32'(overflow), 32'd1);

    // Reset while an entry is queued
    vram_address = 13'h0000;
    A = 16'h4020;
    D = 8'hEE;
    nMREQ = 1'b0;
    nWR = 1'b0;
    for (int i = 0; i < 10 && !wr_pending; i++) tick(1);
    check_eq("t7_queued", 32'(wr_pending), 32'd1);
    nRESET = 1'b0;
    tick(1);
    check_eq("t7_data", 32'(vram_data), 32'h00);
    check_eq("t7_pend", 32'(wr_pending), 32'd0);
    check_eq("t7_ovf", 32'(overflow), 32'd0);
    check_eq("t7_count", 32'(dut.w_count), 32'd0);
    nWR = 1'b1;
    nMREQ = 1'b1;
    nRESET = 1'b1;
    tick(1);
    read_check("t7_recover", 1'b0, 13'h0000);
    cpu_write(16'h4003, 8'h42, 2);
    model[14'h0003] = 8'h42;
    wait_idle("t7_idle");
    read_check("t7_after", 1'b0, 13'h0003);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
